// File: rtl/key_reader_pkg.sv
// key_reader_pkg: shared types and default constants for the key reader
// and its seconds timebase.
package key_reader_pkg;

    // Debounce FSM states: released, confirming a press, held, confirming a release.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } kr_state_e;

    // Board defaults for a 50 MHz clock and a 20 ms debounce window.
    localparam int CLK_HZ_DEF   = 50000000;
    localparam int DEBOUNCE_DEF = 1000000;

endpackage

// File: rtl/key_reader_if.sv
// key_reader_if: button input and the debounced event/duration outputs.
// slave is the key_reader side, master is the consuming user logic
// (which also stands in for the board pin in simulation).
interface key_reader_if #(
    parameter int DUR_W = 8
);
    logic             btn_n;
    logic             pressed;
    logic             press_pulse;
    logic             release_pulse;
    logic [DUR_W-1:0] hold_secs;
    logic [DUR_W-1:0] last_hold;

    modport slave (
        input  btn_n,
        output pressed,
        output press_pulse,
        output release_pulse,
        output hold_secs,
        output last_hold
    );

    modport master (
        output btn_n,
        input  pressed,
        input  press_pulse,
        input  release_pulse,
        input  hold_secs,
        input  last_hold
    );
endinterface

// File: rtl/key_reader_sec_timebase.sv
// sec_timebase: counts 0..CLK_HZ-1 while enabled and emits a one-cycle
// tick on the wrap cycle. clear holds the counter at zero and wins over
// enable, so the first tick after a clear comes a full period later.
module sec_timebase
    import key_reader_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int               CNT_W    = $clog2(CLK_HZ);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = enable && !clear && (cnt == CNT_LAST);

    // Period counter: cleared on request, otherwise advances and wraps while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_reader.sv
// key_reader: synchronizes and debounces an active-low push-button,
// emits one-cycle press/release strobes and measures the hold time in
// whole seconds (saturating).
// Optional feature: define KEY_READER_AUTOREPEAT_EN to also strobe
// press_pulse on every seconds tick while the button stays pressed.
module key_reader
    import key_reader_pkg::*;
#(
    parameter int CLK_HZ          = CLK_HZ_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int DUR_W           = 8
) (
    input  logic          CLOCK_50,
    input  logic          KEY,
    key_reader_if.slave   kr
);

    // The FSM's own entry sample counts as the first stable one, so the
    // counter stops one short of DEBOUNCE_CYCLES-1 when it commits.
    localparam int               DEB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 2);

    logic             btn_sync_p0;
    logic             btn_sync_p1;
    logic             s;
    kr_state_e        state_q, state_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic [DUR_W-1:0] hold_q, hold_d;
    logic [DUR_W-1:0] last_q, last_d;
    logic             pressed;
    logic             tick;

    function automatic logic [DUR_W-1:0] sat_inc(input logic [DUR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign s       = btn_sync_p1;
    assign pressed = (state_q == HELD) || (state_q == RELEASE_WAIT);

    // Two-flop synchronizer for the asynchronous button; resets to released.
    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            btn_sync_p0 <= 1'b1;
            btn_sync_p1 <= 1'b1;
        end else begin
            btn_sync_p0 <= kr.btn_n;
            btn_sync_p1 <= btn_sync_p0;
        end
    end

    sec_timebase #(
        .CLK_HZ (CLK_HZ)
    ) u_timebase (
        .clk    (CLOCK_50),
        .rst_n  (KEY),
        .clear  (!pressed),
        .enable (pressed),
        .tick   (tick)
    );

    // FSM, debounce counter, strobes and duration registers.
    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            hold_q    <= '0;
            last_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            hold_q    <= hold_d;
            last_q    <= last_d;
        end
    end

    // Next-state logic; a tick on the release-commit cycle is folded into last_hold.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        hold_d    = hold_q;
        last_d    = last_q;

        if (tick) begin
            hold_d = sat_inc(hold_q);
        end

        case (state_q)
            IDLE: begin
                if (!s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (s) begin
                    state_d = IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = HELD;
                    press_d = 1'b1;
                    hold_d  = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!s) begin
                    state_d = HELD;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    last_d    = hold_d;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

`ifdef KEY_READER_AUTOREPEAT_EN
        // Typematic repeat, suppressed on the release strobe so the two never overlap.
        if (tick && !release_d) begin
            press_d = 1'b1;
        end
`endif
    end

    assign kr.pressed       = pressed;
    assign kr.press_pulse   = press_q;
    assign kr.release_pulse = release_q;
    assign kr.hold_secs     = hold_q;
    assign kr.last_hold     = last_q;

endmodule
